// File: rtl/multi_switch_toggle.sv
// Multi-channel switch front end: sync, debounce, edge detect, LED toggle.
// Optional long-press detection enabled by defining LONG_PRESS_EN.
module multi_switch_toggle #(
   parameter int NUM_CH          = 4,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int EDGE_MODE       = 0,
   parameter int LONG_CYCLES     = 25000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] sw_in,
   input  logic              clr_in,
   output logic [NUM_CH-1:0] sw_stable,
   output logic [NUM_CH-1:0] edge_pulse,
   output logic [NUM_CH-1:0] led_out,
   output logic [NUM_CH-1:0] long_pulse
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   if (NUM_CH < 1) begin : g_bad_ch
      $error("NUM_CH must be >= 1");
   end
   if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
      $error("DEBOUNCE_CYCLES must be >= 1");
   end
   if (LONG_CYCLES < 1) begin : g_bad_long
      $error("LONG_CYCLES must be >= 1");
   end
   if (EDGE_MODE < 0 || EDGE_MODE > 2) begin : g_bad_mode
      $error("EDGE_MODE must be 0, 1 or 2");
   end

   logic [NUM_CH-1:0] s1;
   logic [NUM_CH-1:0] s2;
   logic [NUM_CH-1:0] stable_q;
   logic [NUM_CH-1:0] rise;
   logic [NUM_CH-1:0] fall;
   logic [NUM_CH-1:0] trig;
   logic [NUM_CH-1:0] keep_fall;
   logic [CW-1:0]     cnt [NUM_CH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= sw_in;
         s2 <= s1;
      end
   end

   // A change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_stable <= '0;
         for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (s2[i] == sw_stable[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               sw_stable[i] <= s2[i];
               cnt[i]       <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   assign rise = sw_stable & ~stable_q;
   assign fall = ~sw_stable & stable_q;

   if (EDGE_MODE == 0) begin : g_mode_rel
      assign trig = fall & keep_fall;
   end else if (EDGE_MODE == 1) begin : g_mode_press
      assign trig = rise;
   end else begin : g_mode_both
      assign trig = rise | (fall & keep_fall);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stable_q   <= '0;
         edge_pulse <= '0;
         led_out    <= '0;
      end else begin
         stable_q   <= sw_stable;
         edge_pulse <= trig;
         led_out    <= clr_in ? '0 : (led_out ^ trig);
      end
   end

`ifdef LONG_PRESS_EN
   localparam int LW = $clog2(LONG_CYCLES + 1);
   localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_CYCLES);
   localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);

   logic [LW-1:0] hold [NUM_CH];

   // Hold counter saturates at LONG_MAX so each press yields one pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         long_pulse <= '0;
         for (int i = 0; i < NUM_CH; i++) hold[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (!sw_stable[i]) begin
               hold[i]       <= '0;
               long_pulse[i] <= 1'b0;
            end else if (hold[i] == LONG_LAST) begin
               hold[i]       <= LONG_MAX;
               long_pulse[i] <= 1'b1;
            end else begin
               long_pulse[i] <= 1'b0;
               if (hold[i] != LONG_MAX) hold[i] <= hold[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      keep_fall = '1;
      for (int i = 0; i < NUM_CH; i++) keep_fall[i] = (hold[i] != LONG_MAX);
   end
`else
   assign long_pulse = '0;
   assign keep_fall  = '1;
`endif

endmodule

// File: tb/tb_multi_switch_toggle.sv
// Directed bench for multi_switch_toggle: edge modes 0/1/2, bounce, clear,
// long press (expectations follow LONG_PRESS_EN) and async reset.
module tb_multi_switch_toggle;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       clr = 1'b0;
   logic [3:0] sw0 = '0, sw1 = '0, sw2 = '0;
   logic [3:0] st0, ep0, led0, lp0;
   logic [3:0] st1, ep1, led1, lp1;
   logic [3:0] st2, ep2, led2, lp2;

   int checks = 0;
   int errors = 0;

`ifdef LONG_PRESS_EN
   localparam bit LP = 1'b1;
`else
   localparam bit LP = 1'b0;
`endif

   always #5 clk = ~clk;

   multi_switch_toggle #(.NUM_CH(4), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0), .LONG_CYCLES(20)) u0 (
      .clk(clk), .rst_n(rst_n), .sw_in(sw0), .clr_in(clr),
      .sw_stable(st0), .edge_pulse(ep0), .led_out(led0), .long_pulse(lp0));

   multi_switch_toggle #(.NUM_CH(4), .DEBOUNCE_CYCLES(4), .EDGE_MODE(1), .LONG_CYCLES(20)) u1 (
      .clk(clk), .rst_n(rst_n), .sw_in(sw1), .clr_in(clr),
      .sw_stable(st1), .edge_pulse(ep1), .led_out(led1), .long_pulse(lp1));

   multi_switch_toggle #(.NUM_CH(4), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2), .LONG_CYCLES(20)) u2 (
      .clk(clk), .rst_n(rst_n), .sw_in(sw2), .clr_in(clr),
      .sw_stable(st2), .edge_pulse(ep2), .led_out(led2), .long_pulse(lp2));

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      sw0 = 4'hF; sw1 = 4'hF; sw2 = 4'hF;
      tick(3);
      checks++;
      if ({st0, ep0, led0, lp0} !== 16'h0) begin
         errors++;
         $display("FAIL reset_u0 got %h exp 0000", {st0, ep0, led0, lp0});
      end
      checks++;
      if ({st2, ep2, led2, lp2, st1, led1} !== 24'h0) begin
         errors++;
         $display("FAIL reset_u1u2 got %h exp 000000", {st2, ep2, led2, lp2, st1, led1});
      end
      sw0 = '0; sw1 = '0; sw2 = '0;
      tick(2);
      rst_n = 1'b1;
      tick(2);
   endtask

   task automatic test_press_release;
      sw0 = 4'b0001; sw1 = 4'b0001;
      for (int k = 1; k <= 9; k++) begin
         tick(1);
         checks++;
         if (st0[0] !== (k >= 6)) begin
            errors++;
            $display("FAIL press_stable k=%0d got %b exp %b", k, st0[0], k >= 6);
         end
         checks++;
         if (ep0 !== 4'b0) begin
            errors++;
            $display("FAIL press_no_pulse_m0 k=%0d got %b exp 0000", k, ep0);
         end
         checks++;
         if (ep1[0] !== (k == 7) || led1[0] !== (k >= 7)) begin
            errors++;
            $display("FAIL press_m1 k=%0d got ep=%b led=%b exp ep=%b led=%b",
                     k, ep1[0], led1[0], k == 7, k >= 7);
         end
      end
      checks++;
      if (led0 !== 4'b0) begin
         errors++;
         $display("FAIL press_no_toggle got %b exp 0000", led0);
      end
      sw0 = '0; sw1 = '0;
      for (int k = 1; k <= 9; k++) begin
         tick(1);
         checks++;
         if (st0[0] !== (k < 6)) begin
            errors++;
            $display("FAIL release_stable k=%0d got %b exp %b", k, st0[0], k < 6);
         end
         checks++;
         if (ep0[0] !== (k == 7) || led0[0] !== (k >= 7)) begin
            errors++;
            $display("FAIL release_toggle k=%0d got ep=%b led=%b exp ep=%b led=%b",
                     k, ep0[0], led0[0], k == 7, k >= 7);
         end
         checks++;
         if (ep1[0] !== 1'b0 || led1[0] !== 1'b1) begin
            errors++;
            $display("FAIL release_m1 k=%0d got ep=%b led=%b exp ep=0 led=1", k, ep1[0], led1[0]);
         end
      end
   endtask

   task automatic test_bounce;
      for (int i = 0; i < 20; i++) begin
         sw0[1] = ((i / 2) % 2 == 0);
         tick(1);
         checks++;
         if (st0[1] !== 1'b0 || ep0[1] !== 1'b0) begin
            errors++;
            $display("FAIL bounce i=%0d got st=%b ep=%b exp st=0 ep=0", i, st0[1], ep0[1]);
         end
      end
      sw0[1] = 1'b1;
      tick(5);
      checks++;
      if (st0[1] !== 1'b0) begin
         errors++;
         $display("FAIL bounce_settle5 got %b exp 0", st0[1]);
      end
      tick(1);
      checks++;
      if (st0[1] !== 1'b1) begin
         errors++;
         $display("FAIL bounce_settle6 got %b exp 1", st0[1]);
      end
      tick(1);
      checks++;
      if (ep0[1] !== 1'b0 || led0[1] !== 1'b0) begin
         errors++;
         $display("FAIL bounce_press got ep=%b led=%b exp ep=0 led=0", ep0[1], led0[1]);
      end
      sw0[1] = 1'b0;
      tick(8);
      checks++;
      if (led0 !== 4'b0011) begin
         errors++;
         $display("FAIL bounce_release got %b exp 0011", led0);
      end
   endtask

   task automatic test_both_edges;
      int pulses = 0;
      int n = 0;
      for (int rep = 0; rep < 2; rep++) begin
         for (int ph = 0; ph < 2; ph++) begin
            sw2[2] = (ph == 0);
            n++;
            for (int k = 1; k <= 10; k++) begin
               tick(1);
               if (ep2[2]) pulses++;
               if (k == 7) begin
                  checks++;
                  if (ep2 !== 4'b0100 || led2[2] !== n[0]) begin
                     errors++;
                     $display("FAIL both_edge n=%0d got ep=%b led=%b exp ep=0100 led=%b",
                              n, ep2, led2[2], n[0]);
                  end
               end
            end
         end
      end
      checks++;
      if (pulses != 4) begin
         errors++;
         $display("FAIL both_count got %0d exp 4", pulses);
      end
   endtask

   task automatic test_clear;
      sw0[3] = 1'b1;
      tick(10);
      sw0[3] = 1'b0;
      tick(6);
      checks++;
      if (led0 !== 4'b0011 || ep0 !== 4'b0) begin
         errors++;
         $display("FAIL clear_pre got led=%b ep=%b exp led=0011 ep=0000", led0, ep0);
      end
      clr = 1'b1;
      tick(1);
      checks++;
      if (ep0 !== 4'b1000) begin
         errors++;
         $display("FAIL clear_pulse got %b exp 1000", ep0);
      end
      checks++;
      if (led0 !== 4'b0 || led1 !== 4'b0) begin
         errors++;
         $display("FAIL clear_led got u0=%b u1=%b exp 0000", led0, led1);
      end
      clr = 1'b0;
      tick(1);
      checks++;
      if (ep0 !== 4'b0 || led0 !== 4'b0 || st0 !== 4'b0) begin
         errors++;
         $display("FAIL clear_post got ep=%b led=%b st=%b exp 0", ep0, led0, st0);
      end
   endtask

   task automatic test_long_press;
      int lpc = 0;
      int epc = 0;
      sw0[0] = 1'b1;
      for (int k = 0; k < 30; k++) begin
         tick(1);
         if (lp0[0]) lpc++;
         if (ep0[0]) epc++;
      end
      sw0[0] = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick(1);
         if (lp0[0]) lpc++;
         if (ep0[0]) epc++;
      end
      checks++;
      if (lpc != (LP ? 1 : 0)) begin
         errors++;
         $display("FAIL long_pulse_cnt got %0d exp %0d", lpc, LP ? 1 : 0);
      end
      checks++;
      if (epc != (LP ? 0 : 1) || led0[0] !== !LP) begin
         errors++;
         $display("FAIL long_release got ep=%0d led=%b exp ep=%0d led=%b",
                  epc, led0[0], LP ? 0 : 1, !LP);
      end
      lpc = 0;
      epc = 0;
      sw0[0] = 1'b1;
      tick(10);
      sw0[0] = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick(1);
         if (lp0[0]) lpc++;
         if (ep0[0]) epc++;
      end
      checks++;
      if (lpc != 0 || epc != 1 || led0[0] !== LP) begin
         errors++;
         $display("FAIL short_press got lp=%0d ep=%0d led=%b exp lp=0 ep=1 led=%b",
                  lpc, epc, led0[0], LP);
      end
   endtask

   task automatic test_async_reset;
      sw0 = 4'hF; sw2 = 4'hF;
      tick(8);
      checks++;
      if (st0 !== 4'hF || led2 !== 4'hF) begin
         errors++;
         $display("FAIL areset_pre got st=%b led2=%b exp 1111 1111", st0, led2);
      end
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (st0 !== 4'h0 || led2 !== 4'h0 || st2 !== 4'h0 || led0 !== 4'h0) begin
         errors++;
         $display("FAIL areset_now got st0=%b led0=%b st2=%b led2=%b exp 0",
                  st0, led0, st2, led2);
      end
      tick(3);
      checks++;
      if ({st0, ep0, led0, lp0, st2, ep2, led2} !== 28'h0) begin
         errors++;
         $display("FAIL areset_hold got %h exp 0", {st0, ep0, led0, lp0, st2, ep2, led2});
      end
      rst_n = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick(1);
         if (k >= 5) begin
            checks++;
            if (st0 !== ((k == 6) ? 4'hF : 4'h0)) begin
               errors++;
               $display("FAIL areset_requal k=%0d got %b exp %b",
                        k, st0, (k == 6) ? 4'hF : 4'h0);
            end
         end
      end
      sw0 = '0; sw2 = '0;
   endtask

   initial begin
      test_reset;
      test_press_release;
      test_bounce;
      test_both_edges;
      test_clear;
      test_long_press;
      test_async_reset;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
